// File: rtl/axi_read_responder.sv
// AXI4 read-channel responder with a 64-bit backing store, fixed first-beat latency and INCR bursts.
// Defining AXI_RESP_DECERR_EN makes bursts starting beyond the store return zero data with DECERR.
module axi_read_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_axi_arvalid,
  input  logic [63:0] m_axi_araddr,
  input  logic [7:0]  m_axi_arlen,
  input  logic [2:0]  m_axi_arsize,
  output logic        m_axi_arready,
  output logic        m_axi_rvalid,
  output logic [63:0] m_axi_rdata,
  output logic [1:0]  m_axi_rresp,
  output logic        m_axi_rlast,
  input  logic        m_axi_rready,
  input  logic        load_en,
  input  logic [63:0] load_addr,
  input  logic [63:0] load_data
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [7:0] LAT_INIT = 8'(LATENCY - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  logic [63:0] r_mem [MEM_WORDS];

  logic [1:0]  r_state;
  logic [63:0] r_addr;
  logic [7:0]  r_len;
  logic [1:0]  r_size;
  logic [7:0]  r_beat;
  logic [7:0]  r_lat;
  logic [63:0] r_rdata;
  logic        r_decerr;

  logic          w_idle;
  logic          w_burst;
  logic          w_ar_fire;
  logic          w_last;
  logic          w_load;
  logic [1:0]    w_size;
  logic [AW-1:0] w_ar_idx;
  logic [AW-1:0] w_cur_idx;
  logic [AW-1:0] w_next_idx;
  logic [AW-1:0] w_load_idx;
  logic [63:0]   w_next_addr;
  logic [63:0]   w_ar_word;
  logic          w_ar_decerr;
  logic          w_unused;

  assign w_idle      = (r_state == S_IDLE);
  assign w_burst     = (r_state == S_BURST);
  assign w_ar_fire   = m_axi_arvalid && m_axi_arready;
  assign w_last      = w_burst && (r_beat == r_len);
  assign w_load      = load_en && w_idle && !reset;
  assign w_size      = (m_axi_arsize > 3'd3) ? 2'd3 : m_axi_arsize[1:0];
  assign w_ar_idx    = m_axi_araddr[3 +: AW];
  assign w_cur_idx   = r_addr[3 +: AW];
  assign w_next_addr = r_addr + (64'd1 << r_size);
  assign w_next_idx  = w_next_addr[3 +: AW];
  assign w_load_idx  = load_addr[AW-1:0];
  assign w_unused    = ^load_addr[63:AW];

  // With LATENCY=1 the first word is fetched on the accept edge, so a same-edge load must bypass the array.
  assign w_ar_word = (w_load && (w_load_idx == w_ar_idx)) ? load_data : r_mem[w_ar_idx];

`ifdef AXI_RESP_DECERR_EN
  assign w_ar_decerr = |m_axi_araddr[63:AW+3];
  assign m_axi_rresp = (w_burst && r_decerr) ? 2'b11 : 2'b00;
`else
  assign w_ar_decerr = 1'b0;
  assign m_axi_rresp = 2'b00;
`endif

  assign m_axi_arready = w_idle && !reset;
  assign m_axi_rvalid  = w_burst;
  assign m_axi_rlast   = w_last;
  assign m_axi_rdata   = r_rdata;

  // Backing store is deliberately left out of reset so boot images survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_mem[w_load_idx] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_addr   <= 64'd0;
      r_len    <= 8'd0;
      r_size   <= 2'd0;
      r_beat   <= 8'd0;
      r_lat    <= 8'd0;
      r_rdata  <= 64'd0;
      r_decerr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ar_fire) begin
            r_addr   <= m_axi_araddr;
            r_len    <= m_axi_arlen;
            r_size   <= w_size;
            r_beat   <= 8'd0;
            r_lat    <= LAT_INIT;
            r_decerr <= w_ar_decerr;
            if (LATENCY == 1) begin
              r_rdata <= w_ar_decerr ? 64'd0 : w_ar_word;
              r_state <= S_BURST;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_lat == 8'd0) begin
            r_rdata <= r_decerr ? 64'd0 : r_mem[w_cur_idx];
            r_state <= S_BURST;
          end else begin
            r_lat <= r_lat - 8'd1;
          end
        end
        S_BURST: begin
          if (m_axi_rready) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_addr  <= w_next_addr;
              r_beat  <= r_beat + 8'd1;
              r_rdata <= r_decerr ? 64'd0 : r_mem[w_next_idx];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_read_responder.md
# axi_read_responder

AXI4 read-channel responder (slave end) for the instruction-fetch and cache read path. It accepts one AR request at a time and holds a 64-bit-wide backing memory. After a fixed latency it returns an INCR burst of `arlen+1` beats on the R channel, honouring `rready` back-pressure. It is the memory-side counterpart of the fetch/cache AXI read initiator and serves as the system memory model in simulation and as the boot-ROM port in synthesis.

## Interface
- `MEM_WORDS`, 1024: backing store depth in 64-bit words; must be a power of two.
- `LATENCY`, 2: cycles from AR handshake edge to first `rvalid`; legal range 1..255.
- `clk` input 1: clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `m_axi_arvalid` input 1: read address valid.
- `m_axi_araddr` input 64: byte address of first beat.
- `m_axi_arlen` input 8: beats minus one.
- `m_axi_arsize` input 3: log2 bytes per beat, 0..3.
- `m_axi_arready` output 1: address accept.
- `m_axi_rvalid` output 1: read data valid.
- `m_axi_rdata` output 64: read data.
- `m_axi_rresp` output 2: response code.
- `m_axi_rlast` output 1: final beat of burst.
- `m_axi_rready` input 1: initiator ready for data.
- `load_en` input 1: backdoor write strobe.
- `load_addr` input 64: backdoor word index; bits above log2(MEM_WORDS) ignored.
- `load_data` input 64: backdoor write data.

## Operation
- States: IDLE, WAIT, BURST.
- IDLE:
  - `arready`=1. On `arvalid&&arready`, latch `araddr`, `arlen`, `arsize`.
  - Clear the beat counter. Load the latency counter with `LATENCY-1`.
  - Go to WAIT, or to BURST directly if `LATENCY`=1.
- WAIT:
  - `arready`=0. Decrement the latency counter each cycle.
  - At 0, fetch word `addr[3+:log2(MEM_WORDS)]` into the rdata register and go to BURST.
- BURST:
  - `rvalid`=1.
  - `rlast`=1 exactly when beat counter == latched `arlen`.
  - On `rvalid&&rready` and not last: advance address by `1<<arsize` (INCR, 64-bit add, no 4 KB boundary check), increment the beat counter, and register the next word.
  - On the last handshake, return to IDLE.
- Beat data is always the full aligned 64-bit word containing the current beat address, regardless of `arsize`. `arsize` only sets the address stride.
- `arsize` > 3 is treated as 3.
- Word index wraps modulo `MEM_WORDS`.
- Backdoor load:
  - `load_en` is honoured only in IDLE and writes `mem[load_addr]` on the edge.
  - `load_en` outside IDLE is ignored.
  - Load and AR handshake on the same edge: the write completes first, and the burst returns the new data.
- `rresp` = 2'b00 (OKAY) unless `AXI_RESP_DECERR_EN` is defined.

## Timing
- Reset values: `arready`=0 while `reset` is high; `rvalid`=0; `rlast`=0; `rdata`=0; `rresp`=0; state IDLE.
- `arready`=1 on the first cycle after reset deasserts.
- Memory contents are not reset.
- AR handshake on edge k: `rvalid` rises after edge k+`LATENCY`.
- With `rready` held high, beats follow on consecutive cycles. An N-beat burst occupies `LATENCY`+N cycles from the accept edge.
- While `rvalid&&!rready`: `rdata`, `rresp` and `rlast` are held stable, and the address and counter do not advance.
- After the last handshake, `rvalid` and `rlast` drop on the next cycle and `arready` is 1 in that same cycle. There are no back-to-back bursts without one IDLE cycle.
- Reset asserted mid-burst clears outputs immediately (asynchronous) and abandons the burst. No `rlast` is produced.
- `arlen`=0: a single beat with `rlast`=1.
- `arlen`=255: 256 beats. The beat counter is 8 bits and must not wrap before `rlast`.

## Configuration
- `AXI_RESP_DECERR_EN` defined:
  - A burst is decoded as out of range when `araddr` ≥ `MEM_WORDS*8`.
  - Such a burst returns every beat with `rdata`=0 and `rresp`=2'b11 (DECERR), with normal beat count, `rlast` and latency.
  - The check is made once, at AR accept.
- Not defined:
  - No range check; the address wraps modulo the memory size.
  - `rresp` is constant 2'b00.

## Test plan
- Single beat: load `mem[4]`=64'hDEADBEEF_00000013, AR `araddr`=0x20, `arlen`=0, `arsize`=3, `rready`=1 -> `rvalid` after edge accept+2, `rdata`=64'hDEADBEEF_00000013, `rlast`=1, `rresp`=0, `arready` back next cycle.
- Burst with back-pressure: load `mem[0..7]`=i+1, AR `araddr`=0, `arlen`=7, `rready` toggling 1,0,0,1,... -> 8 beats of data 1..8 in order, data held while stalled, `rlast` only on beat 8.
- Stride: `arsize`=2, `araddr`=0x0, `arlen`=3 -> beats return `mem[0]`, `mem[0]`, `mem[1]`, `mem[1]`.
- Wrap: `MEM_WORDS`=1024, `araddr`=0x1FF8, `arlen`=1 -> beats `mem[1023]` then `mem[0]` (macro off).
- Reset mid-burst: assert `reset` on beat 3 of an `arlen`=7 burst -> `rvalid`/`rlast` 0 immediately. After release, `arready`=1, and a new AR `arlen`=0 returns correct data.
- `AXI_RESP_DECERR_EN`: AR `araddr`=`MEM_WORDS*8`, `arlen`=2 -> 3 beats with `rdata`=0, `rresp`=2'b11, `rlast` on the third beat.
